// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the built-in self-test blocks: the sequencer state
// encoding, the 16-bit Galois LFSR tap mask, the default seed and the LFSR
// step function used by every block that needs to look one step ahead.
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One right-shift Galois step: when the bit shifted out is 1 the taps are folded in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ LFSR_TAPS;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// -----------------------------------------------------------------------------
// lfsr16_galois
// 16-bit right-shifting Galois LFSR with synchronous load and advance.
// Load has priority over advance; with neither asserted the value holds.
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset (value <= RESET_VAL)
//   load   in   1   load seed on the next edge
//   seed   in   16  value to load
//   adv    in   1   step the sequence on the next edge
//   value  out  16  current LFSR state (registered)
// -----------------------------------------------------------------------------
module lfsr16_galois
    import bist_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        adv,
    output logic [15:0] value
);

    // LFSR state register: reset, load, advance or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_VAL;
        end else if (load) begin
            value <= seed;
        end else if (adv) begin
            value <= lfsr_next(value);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/decoder_lockstep_bist.sv
// -----------------------------------------------------------------------------
// decoder_lockstep_bist
// Drives LFSR stimulus into a reference and a candidate decoder, compares
// their responses in lockstep, counts mismatches (saturating) and captures
// the first failing vector. Each vector is held SETTLE_CYC cycles, then
// sampled in one CHECK cycle, so a run takes N_VECTORS*(SETTLE_CYC+1) cycles.
// Ports:
//   clk            in   1          rising-edge clock
//   rst_n          in   1          asynchronous active-low reset
//   start          in   1          begin a run (honoured only in IDLE or DONE)
//   stim           out  STIM_W     stimulus to both decoders (registered)
//   resp_a         in   RESP_W     reference response
//   resp_b         in   RESP_W     candidate response
//   busy           out  1          run in progress
//   done           out  1          run complete, held until next start/reset
//   pass           out  1          valid with done: no mismatches
//   err_count      out  ERR_CNT_W  mismatches this run, saturating
//   first_err_vld  out  1          first mismatch captured
//   first_err_idx  out  16         vector index of first mismatch
//   first_err_stim out  STIM_W     stimulus of first mismatch
// -----------------------------------------------------------------------------
module decoder_lockstep_bist
    import bist_pkg::*;
#(
    parameter int          STIM_W     = 7,
    parameter int          RESP_W     = 3,
    parameter int          N_VECTORS  = 100,
    parameter int          SETTLE_CYC = 1,
    parameter int          ERR_CNT_W  = 8,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [STIM_W-1:0]    stim,
    input  logic [RESP_W-1:0]    resp_a,
    input  logic [RESP_W-1:0]    resp_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_vld,
    output logic [15:0]          first_err_idx,
    output logic [STIM_W-1:0]    first_err_stim
);

    localparam int                 SET_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0]   SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [15:0]        LAST_IDX = 16'(N_VECTORS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    // Elaboration-time parameter checks.
    generate
        if (STIM_W < 1 || STIM_W > 16) begin : g_bad_stim_w
            $error("decoder_lockstep_bist: STIM_W must be 1..16");
        end
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("decoder_lockstep_bist: SETTLE_CYC must be >= 1");
        end
        if (N_VECTORS < 1 || N_VECTORS > 65536) begin : g_bad_nvec
            $error("decoder_lockstep_bist: N_VECTORS must be 1..65536");
        end
        if (SEED == 16'h0000) begin : g_bad_seed
            $error("decoder_lockstep_bist: SEED must be nonzero");
        end
    endgenerate

    bist_state_t          state_r;
    logic [SET_W-1:0]     settle_cnt_r;
    logic [15:0]          idx_r;
    logic [15:0]          lfsr_val_s;
    logic [15:0]          lfsr_nxt_s;
    logic [STIM_W-1:0]    stim_nxt_s;
    logic                 start_ok_s;
    logic                 lfsr_adv_s;
    logic                 mismatch_s;
    logic [ERR_CNT_W-1:0] err_nxt_s;

    lfsr16_galois #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok_s),
        .seed  (SEED),
        .adv   (lfsr_adv_s),
        .value (lfsr_val_s)
    );

    // Upper LFSR bits beyond the stimulus width only feed the sequence itself.
    generate
        if (STIM_W < 16) begin : g_unused_hi
            logic unused_lfsr_hi_s;
            assign unused_lfsr_hi_s = ^lfsr_nxt_s[15:STIM_W];
        end
    endgenerate

    // Next-step values, start qualification and the saturating error increment.
    always_comb begin
        lfsr_nxt_s = lfsr_next(lfsr_val_s);
        stim_nxt_s = lfsr_nxt_s[STIM_W-1:0];
        // Case equality so that X/Z on either response is flagged in simulation.
        mismatch_s = (resp_a !== resp_b);
        if (start && (state_r == IDLE || state_r == DONE)) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
        // The LFSR steps in lockstep with stim on every CHECK that is not the last.
        if (state_r == CHECK && idx_r != LAST_IDX) begin
            lfsr_adv_s = 1'b1;
        end else begin
            lfsr_adv_s = 1'b0;
        end
        if (mismatch_s && err_count != ERR_MAX) begin
            err_nxt_s = err_count + ERR_CNT_W'(1);
        end else begin
            err_nxt_s = err_count;
        end
    end

    // Sequencer: state, counters, stimulus and all result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            settle_cnt_r   <= {SET_W{1'b0}};
            idx_r          <= 16'd0;
            stim           <= {STIM_W{1'b0}};
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= {ERR_CNT_W{1'b0}};
            first_err_vld  <= 1'b0;
            first_err_idx  <= 16'd0;
            first_err_stim <= {STIM_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r        <= SETTLE;
                        settle_cnt_r   <= {SET_W{1'b0}};
                        idx_r          <= 16'd0;
                        stim           <= SEED[STIM_W-1:0];
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= {ERR_CNT_W{1'b0}};
                        first_err_vld  <= 1'b0;
                        first_err_idx  <= 16'd0;
                        first_err_stim <= {STIM_W{1'b0}};
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == SET_LAST) begin
                        settle_cnt_r <= {SET_W{1'b0}};
                        state_r      <= CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SET_W'(1);
                    end
                end
                CHECK: begin
                    err_count <= err_nxt_s;
                    if (mismatch_s && !first_err_vld) begin
                        first_err_vld  <= 1'b1;
                        first_err_idx  <= idx_r;
                        first_err_stim <= stim;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // Includes the vector checked in this very cycle.
                        pass    <= (err_nxt_s == {ERR_CNT_W{1'b0}});
                    end else begin
                        state_r <= SETTLE;
                        stim    <= stim_nxt_s;
                        idx_r   <= idx_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
